// File: rtl/assoc_cache.sv
// Set-associative, one-word-line cache with true-LRU replacement and a
// parameterizable write-back/write-allocate or write-through/no-allocate policy.
module assoc_cache #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int WAYS       = 2,
   parameter int SETS       = 4,
   parameter int WRITE_BACK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic [DATA_W-1:0] cpu_write_data,
   output logic [DATA_W-1:0] cpu_read_data,
   output logic              cpu_hit,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic              mem_ack
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam bit WB    = (WRITE_BACK != 0);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOOKUP = 3'd1;
   localparam logic [2:0] WBACK  = 3'd2;
   localparam logic [2:0] FILL   = 3'd3;
   localparam logic [2:0] WTHRU  = 3'd4;
   localparam logic [2:0] RESP   = 3'd5;

   logic [2:0]        state_reg;
   logic              req_write_reg;
   logic [ADDR_W-1:0] req_addr_reg;
   logic [DATA_W-1:0] req_wdata_reg;
   logic [WAY_W-1:0]  way_reg;
   logic              hit_reg;
   logic [DATA_W-1:0] resp_data_reg;

   logic              valid_reg [WAYS][SETS];
   logic              dirty_reg [WAYS][SETS];
   logic [WAY_W-1:0]  age_reg   [WAYS][SETS];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  req_tag;
   logic              accept;
   logic [WAYS-1:0]   hit_vec;
   logic              hit_any;
   logic [WAY_W-1:0]  hit_way;
   logic [WAY_W-1:0]  victim_way;
   logic              victim_dirty;
   logic              lookup_ready;
   logic              line_we;
   logic [WAY_W-1:0]  line_way;
   logic [DATA_W-1:0] line_data;
   logic              lru_en;
   logic [WAY_W-1:0]  lru_way;
   logic [TAG_W-1:0]  rd_tag_w  [WAYS];
   logic [DATA_W-1:0] rd_data_w [WAYS];

   assign idx     = req_addr_reg[IDX_W-1:0];
   assign req_tag = req_addr_reg[ADDR_W-1:IDX_W];
   assign accept  = (state_reg == IDLE) && cpu_req;

   // Tag/data live in per-way RAMs read once at acceptance; the registered
   // copy stays valid for the whole transaction since only it touches the set.
   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         logic [TAG_W-1:0]  tag_mem  [SETS];
         logic [DATA_W-1:0] data_mem [SETS];
         logic [TAG_W-1:0]  rd_tag_reg;
         logic [DATA_W-1:0] rd_data_reg;

         always_ff @(posedge clk) begin
            if (line_we && line_way == WAY_W'(gi)) begin
               tag_mem[idx]  <= req_tag;
               data_mem[idx] <= line_data;
            end
            if (accept) begin
               rd_tag_reg  <= tag_mem[cpu_address[IDX_W-1:0]];
               rd_data_reg <= data_mem[cpu_address[IDX_W-1:0]];
            end
         end

         assign rd_tag_w[gi]  = rd_tag_reg;
         assign rd_data_w[gi] = rd_data_reg;
         assign hit_vec[gi]   = valid_reg[gi][idx] && (rd_tag_reg == req_tag);
      end
   endgenerate

   assign hit_any = |hit_vec;

   // Victim: lowest-index invalid way, otherwise the oldest (age WAYS-1).
   always_comb begin
      hit_way    = '0;
      victim_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_vec[w]) hit_way = WAY_W'(w);
         if (age_reg[w][idx] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_reg[w][idx]) victim_way = WAY_W'(w);
      end
   end

   assign victim_dirty = valid_reg[victim_way][idx] && dirty_reg[victim_way][idx];
   assign lookup_ready = (state_reg == LOOKUP) && hit_any && !(req_write_reg && !WB);

   assign line_we   = ((state_reg == LOOKUP) && hit_any && req_write_reg) ||
                      ((state_reg == FILL) && mem_ack);
   assign line_way  = (state_reg == LOOKUP) ? hit_way : way_reg;
   assign line_data = req_write_reg ? req_wdata_reg : mem_read_data;
   assign lru_en    = ((state_reg == LOOKUP) && hit_any) || ((state_reg == FILL) && mem_ack);
   assign lru_way   = line_way;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         req_write_reg <= 1'b0;
         req_addr_reg  <= '0;
         req_wdata_reg <= '0;
         way_reg       <= '0;
         hit_reg       <= 1'b0;
         resp_data_reg <= '0;
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid_reg[w][s] <= 1'b0;
               dirty_reg[w][s] <= 1'b0;
               age_reg[w][s]   <= WAY_W'(w);
            end
         end
      end else begin
         if (lru_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == lru_way)
                  age_reg[w][idx] <= '0;
               else if (age_reg[w][idx] < age_reg[lru_way][idx])
                  age_reg[w][idx] <= age_reg[w][idx] + WAY_W'(1);
            end
         end
         case (state_reg)
            IDLE: begin
               if (cpu_req) begin
                  req_write_reg <= cpu_write;
                  req_addr_reg  <= cpu_address;
                  req_wdata_reg <= cpu_write_data;
                  state_reg     <= LOOKUP;
               end
            end
            LOOKUP: begin
               hit_reg <= hit_any;
               if (hit_any) begin
                  way_reg <= hit_way;
                  if (req_write_reg && WB) dirty_reg[hit_way][idx] <= 1'b1;
                  state_reg <= (req_write_reg && !WB) ? WTHRU : IDLE;
               end else begin
                  way_reg <= victim_way;
                  if (req_write_reg && !WB)  state_reg <= WTHRU;
                  else if (WB && victim_dirty) state_reg <= WBACK;
                  else                       state_reg <= FILL;
               end
            end
            WBACK: if (mem_ack) state_reg <= FILL;
            FILL: begin
               if (mem_ack) begin
                  valid_reg[way_reg][idx] <= 1'b1;
                  dirty_reg[way_reg][idx] <= WB && req_write_reg;
                  resp_data_reg           <= line_data;
                  state_reg               <= RESP;
               end
            end
            WTHRU: if (mem_ack) state_reg <= RESP;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign cpu_ready = lookup_ready || (state_reg == RESP);
   assign cpu_hit   = lookup_ready || ((state_reg == RESP) && hit_reg);

   always_comb begin
      cpu_read_data  = '0;
      mem_req        = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      if (lookup_ready)            cpu_read_data = rd_data_w[hit_way];
      else if (state_reg == RESP)  cpu_read_data = resp_data_reg;
      case (state_reg)
         WBACK: begin
            mem_req        = 1'b1;
            mem_write      = 1'b1;
            mem_address    = {rd_tag_w[way_reg], idx};
            mem_write_data = rd_data_w[way_reg];
         end
         FILL: begin
            mem_req     = 1'b1;
            mem_address = req_addr_reg;
         end
         WTHRU: begin
            mem_req        = 1'b1;
            mem_write      = 1'b1;
            mem_address    = req_addr_reg;
            mem_write_data = req_wdata_reg;
         end
         default: ;
      endcase
   end
endmodule
